dec5_32_accum: RTL and testbench

Index-to-mask accumulator: the decode-side counterpart of the 32-to-5 priority encoder. It accepts a stream of 5-bit indices over a valid/ready handshake and decodes each to a one-hot word. It ORs each word into a 32-bit mask register and, when the last index of a set is accepted, presents the finished mask with a distinct-bit count and a duplicate flag on an output valid/ready handshake. It rebuilds bit vectors (free-lists, byte/register masks) from index streams that the priority encoder originally scanned out.

---
 rtl/dec5_32_accum.sv | 105 ++++++++++
 tb/tb_dec5_32_accum.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dec5_32_accum.sv
// rtl/dec5_32_accum.sv - index-to-mask accumulator with distinct count and duplicate flag
module dec5_32_accum (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_idx,
  input  logic        in_last,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_mask,
  output logic [5:0]  out_cnt,
  output logic        out_dup,
  output logic [31:0] onehot
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mask_q, mask_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        dup_q, dup_d;
  logic        accept;
  logic        bit_seen;

  // Pure decode of the offered index, independent of any handshake.
  always_comb begin
    onehot = 32'd1 << in_idx;
  end

  // Handshake outputs and the accept qualifier; reset masks in_ready directly
  // so the source sees back-pressure for the whole reset pulse.
  always_comb begin
    in_ready  = (state_q == ACCUM) && !reset;
    out_valid = (state_q == HOLD);
    accept    = in_valid && in_ready && !clear;
    bit_seen  = mask_q[in_idx];
  end

  // Next-state and next-data logic; clear wins over an accept in ACCUM,
  // and HOLD freezes everything until the consumer takes the set.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    dup_d   = dup_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          mask_d = 32'd0;
          cnt_d  = 6'd0;
          dup_d  = 1'b0;
        end else if (accept) begin
          mask_d = mask_q | onehot;
          if (bit_seen) begin
            dup_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          mask_d  = 32'd0;
          cnt_d   = 6'd0;
          dup_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and accumulator registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      mask_q  <= 32'd0;
      cnt_q   <= 6'd0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
    end
  end

  // Finished-set outputs come straight from the registers.
  always_comb begin
    out_mask = mask_q;
    out_cnt  = cnt_q;
    out_dup  = dup_q;
  end

endmodule

// File: tb/tb_dec5_32_accum.sv
// tb/tb_dec5_32_accum.sv - directed self-checking bench for dec5_32_accum
module tb_dec5_32_accum;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_idx;
  logic        in_last;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mask;
  logic [5:0]  out_cnt;
  logic        out_dup;
  logic [31:0] onehot;

  int compared;
  int mismatched;

  dec5_32_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_last   (in_last),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_cnt   (out_cnt),
    .out_dup   (out_dup),
    .onehot    (onehot)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] idx, input logic last);
    in_valid = 1'b1;
    in_idx   = idx;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_set();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_idx     = 5'd0;
    in_last    = 1'b0;
    clear      = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mask", out_mask, 32'h0000_0000);
    check("rst_cnt", {26'd0, out_cnt}, 32'd0);
    check("rst_dup", {31'd0, out_dup}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    tick();
    check("rel_ready", {31'd0, in_ready}, 32'd1);

    // Single-beat set with consumer ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_idx    = 5'd0;
    in_last   = 1'b1;
    #1;
    check("single_onehot", onehot, 32'h0000_0001);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_mask", out_mask, 32'h0000_0001);
    check("single_cnt", {26'd0, out_cnt}, 32'd1);
    check("single_dup", {31'd0, out_dup}, 32'd0);
    check("single_ready_lo", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
    check("single_taken_valid", {31'd0, out_valid}, 32'd0);
    check("single_taken_ready", {31'd1 & 31'd0, in_ready}, 32'd1);

    // Onehot sweep over every index
    for (int i = 0; i < 32; i++) begin
      in_idx = i[4:0];
      #1;
      check($sformatf("onehot_%0d", i), onehot, 32'd1 << i);
    end

    // Multi-beat set on back-to-back cycles
    in_valid = 1'b1;
    in_idx = 5'd31; in_last = 1'b0; tick();
    in_idx = 5'd0;  in_last = 1'b0; tick();
    in_idx = 5'd16; in_last = 1'b1; tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("multi_valid", {31'd0, out_valid}, 32'd1);
    check("multi_mask", out_mask, 32'h8001_0001);
    check("multi_cnt", {26'd0, out_cnt}, 32'd3);
    check("multi_dup", {31'd0, out_dup}, 32'd0);
    take_set();
    check("multi_taken", {31'd0, out_valid}, 32'd0);

    // Duplicate index within a set
    beat(5'd5, 1'b0);
    beat(5'd5, 1'b0);
    beat(5'd7, 1'b1);
    check("dup_mask", out_mask, 32'h0000_00A0);
    check("dup_cnt", {26'd0, out_cnt}, 32'd2);
    check("dup_flag", {31'd0, out_dup}, 32'd1);
    take_set();

    // Backpressure in HOLD, with in_valid and clear that must be ignored
    beat(5'd1, 1'b0);
    beat(5'd2, 1'b1);
    in_valid = 1'b1;
    in_idx   = 5'd10;
    in_last  = 1'b1;
    clear    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp_valid_%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_ready_%0d", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_mask_%0d", c), out_mask, 32'h0000_0006);
      check($sformatf("bp_cnt_%0d", c), {26'd0, out_cnt}, 32'd2);
      tick();
    end
    check("bp_mask_final", out_mask, 32'h0000_0006);
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
    take_set();
    check("bp_taken_valid", {31'd0, out_valid}, 32'd0);
    check("bp_taken_ready", {31'd0, in_ready}, 32'd1);

    // Clear discards the partial set and a simultaneous beat
    beat(5'd3, 1'b0);
    beat(5'd4, 1'b0);
    clear = 1'b1;
    beat(5'd9, 1'b0);
    clear = 1'b0;
    check("clr_ready", {31'd0, in_ready}, 32'd1);
    check("clr_mask_zero", out_mask, 32'h0000_0000);
    beat(5'd2, 1'b1);
    check("clr_valid", {31'd0, out_valid}, 32'd1);
    check("clr_mask", out_mask, 32'h0000_0004);
    check("clr_cnt", {26'd0, out_cnt}, 32'd1);
    check("clr_dup", {31'd0, out_dup}, 32'd0);
    take_set();

    // Reset during HOLD drops out_valid without a clock edge
    beat(5'd8, 1'b0);
    beat(5'd9, 1'b1);
    check("hold_mask", out_mask, 32'h0000_0300);
    #2;
    reset = 1'b1;
    #1;
    check("hrst_valid", {31'd0, out_valid}, 32'd0);
    check("hrst_mask", out_mask, 32'h0000_0000);
    check("hrst_cnt", {26'd0, out_cnt}, 32'd0);
    check("hrst_ready", {31'd0, in_ready}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("hrst_rel_ready", {31'd0, in_ready}, 32'd1);
    check("hrst_rel_mask", out_mask, 32'h0000_0000);

    // Reset mid-set discards the partial mask
    beat(5'd1, 1'b0);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    beat(5'd2, 1'b1);
    check("mrst_mask", out_mask, 32'h0000_0004);
    check("mrst_cnt", {26'd0, out_cnt}, 32'd1);
    take_set();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
